// File: rtl/fir_stream_pkg.sv
// Shared types and default widths for the FIR sample streamer and the filter it feeds.
package fir_stream_pkg;

  localparam int unsigned SAMPLE_W = 17;
  localparam int unsigned TAP_CNT  = 123;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StFlush,
    StDone
  } stream_state_e;

endpackage

// File: rtl/fir_sample_streamer_if.sv
// Valid/ready sample stream from the streamer to the filter's x_in.
interface fir_sample_streamer_if #(
  parameter int unsigned DATA_W = 17
);

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     flush_active;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    output flush_active,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    input  flush_active,
    output out_ready
  );

endinterface

// File: rtl/fir_sample_ram.sv
// Sample table: one synchronous write port, one synchronous read port, no reset.
module fir_sample_ram #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 16384
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/fir_sample_streamer.sv
// Plays a segment of the sample table onto the filter stream, then FLUSH_LEN zero beats.
// Optional stall counter port enabled by FIR_STREAMER_STALL_CNT_EN.
module fir_sample_streamer
  import fir_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = SAMPLE_W,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DEPTH     = 2 ** ADDR_W,
  parameter int unsigned FLUSH_LEN = TAP_CNT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        seg_base,
  input  logic [ADDR_W:0]          seg_len,
  fir_sample_streamer_if.master    stream,
  output logic                     busy,
  output logic                     done
`ifdef FIR_STREAMER_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int unsigned FlushW = $clog2(FLUSH_LEN + 2);
  localparam logic [FlushW-1:0] FlushInit = FlushW'(FLUSH_LEN);
  localparam logic [ADDR_W:0]   DepthLen  = (ADDR_W + 1)'(DEPTH);

  stream_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   play_rem_q, play_rem_d;
  logic [FlushW-1:0] flush_rem_q, flush_rem_d;

  // One beat in flight through the RAM read stage, tagged so flush zeros share its latency.
  logic rd_vld_q, rd_flush_q, rd_last_q;
  logic signed [DATA_W-1:0] ram_rd_data;

  logic signed [DATA_W-1:0] fifo_data_q  [2];
  logic                     fifo_last_q  [2];
  logic                     fifo_flush_q [2];
  logic                     wptr_q, rptr_q;
  logic [1:0]               cnt_q;

  logic out_valid, pop, last_pop, can_issue;
  logic issue_play, issue_flush, issue_last;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & stream.out_ready;
  assign last_pop  = pop & fifo_last_q[rptr_q];
  // Only issue when the beat is guaranteed a buffer slot on arrival.
  assign can_issue = ({1'b0, cnt_q} + {2'b0, rd_vld_q}) < (3'd2 + {2'b0, pop});

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    play_rem_d  = play_rem_q;
    flush_rem_d = flush_rem_q;
    issue_play  = 1'b0;
    issue_flush = 1'b0;
    issue_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = seg_base;
          play_rem_d  = (seg_len > DepthLen) ? DepthLen : seg_len;
          flush_rem_d = FlushInit;
          if (seg_len != '0)        state_d = StPlay;
          else if (FLUSH_LEN != 0) state_d = StFlush;
          else                     state_d = StDone;
        end
      end
      StPlay: begin
        if (play_rem_q != '0 && can_issue) begin
          issue_play = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          play_rem_d = play_rem_q - (ADDR_W + 1)'(1);
          if (play_rem_q == (ADDR_W + 1)'(1)) begin
            if (FLUSH_LEN != 0) state_d = StFlush;
            else                issue_last = 1'b1;
          end
        end
        if (last_pop) state_d = StDone;
      end
      StFlush: begin
        if (flush_rem_q != '0 && can_issue) begin
          issue_flush = 1'b1;
          flush_rem_d = flush_rem_q - FlushW'(1);
          issue_last  = (flush_rem_q == FlushW'(1));
        end
        if (last_pop) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      play_rem_q  <= '0;
      flush_rem_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_flush_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      play_rem_q  <= play_rem_d;
      flush_rem_q <= flush_rem_d;
      rd_vld_q    <= issue_play | issue_flush;
      rd_flush_q  <= issue_flush;
      rd_last_q   <= issue_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_last_q[i]  <= 1'b0;
        fifo_flush_q[i] <= 1'b0;
      end
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (rd_vld_q) begin
        fifo_data_q[wptr_q]  <= rd_flush_q ? '0 : ram_rd_data;
        fifo_last_q[wptr_q]  <= rd_last_q;
        fifo_flush_q[wptr_q] <= rd_flush_q;
        wptr_q               <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
    end
  end

  fir_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en & (state_q == StIdle)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue_play),
    .rd_addr (addr_q),
    .rd_data (ram_rd_data)
  );

  assign stream.out_valid    = out_valid;
  assign stream.out_data     = out_valid ? fifo_data_q[rptr_q] : '0;
  assign stream.out_last     = out_valid & fifo_last_q[rptr_q];
  assign stream.flush_active = out_valid & fifo_flush_q[rptr_q];
  assign busy                = (state_q == StPlay) || (state_q == StFlush);
  assign done                = (state_q == StDone);

`ifdef FIR_STREAMER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == StIdle && start) begin
      stall_q <= '0;
    end else if (out_valid && !stream.out_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Bench: three streamers (FLUSH_LEN 2, 123, 0) driven in lockstep and checked against a
// segment-level model of the sample table.
module tb_fir_sample_streamer;
  import fir_stream_pkg::*;

  localparam int unsigned DW    = 17;
  localparam int unsigned AW    = 14;
  localparam int          DEPTH = 16384;
  localparam int          NDUT  = 3;

  typedef struct packed {
    logic signed [DW-1:0] data;
    logic                 last;
    logic                 flush;
  } beat_t;

  typedef struct {
    int base;
    int len;
    int mode;
    int exp_beats_g0;
  } seg_vec_t;

  logic clk = 1'b0;
  logic reset;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic signed [DW-1:0] wr_data;
  logic start_v [NDUT];
  logic [AW-1:0] seg_base;
  logic [AW:0] seg_len;
  logic ready;

  logic valid_w [NDUT];
  logic last_w  [NDUT];
  logic flush_w [NDUT];
  logic busy_w  [NDUT];
  logic done_w  [NDUT];
  logic signed [DW-1:0] data_w [NDUT];
`ifdef FIR_STREAMER_STALL_CNT_EN
  logic [31:0] stall_w [NDUT];
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_mode = 0;
  int rk = 0;
  logic cap_en = 1'b0;

  logic signed [DW-1:0] ram_m [DEPTH];
  beat_t got_q [NDUT][$];
  int first_cyc [NDUT];
  int last_cyc  [NDUT];
  int done_cyc  [NDUT];
  int done_cnt  [NDUT];
  int stall_m   [NDUT];
  logic prev_stall [NDUT];
  beat_t prev_beat [NDUT];
  beat_t mon_cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned FL = (g == 0) ? 2 : (g == 1) ? 123 : 0;
    fir_sample_streamer_if #(.DATA_W(DW)) sif ();
    assign sif.out_ready = ready;
    fir_sample_streamer #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .DEPTH     (DEPTH),
      .FLUSH_LEN (FL)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start_v[g]),
      .seg_base  (seg_base),
      .seg_len   (seg_len),
      .stream    (sif),
      .busy      (busy_w[g]),
      .done      (done_w[g])
`ifdef FIR_STREAMER_STALL_CNT_EN
      ,
      .stall_cnt (stall_w[g])
`endif
    );
    assign valid_w[g] = sif.out_valid;
    assign data_w[g]  = sif.out_data;
    assign last_w[g]  = sif.out_last;
    assign flush_w[g] = sif.flush_active;
  end

  function automatic int fl_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 123 : 0;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t got, input beat_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got data=%0d last=%0b flush=%0b, want data=%0d last=%0b flush=%0b",
               nm, $signed(got.data), got.last, got.flush, $signed(exp.data), exp.last,
               exp.flush);
    end
  endtask

  // Beat capture, stall accounting and hold-stable check, sampled mid-cycle.
  always @(negedge clk) begin
    if (cap_en) begin
      for (int g = 0; g < NDUT; g++) begin
        mon_cur.data  = data_w[g];
        mon_cur.last  = last_w[g];
        mon_cur.flush = flush_w[g];
        if (prev_stall[g]) begin
          n_vec++;
          if (!valid_w[g] || mon_cur !== prev_beat[g]) begin
            n_err++;
            $display("FAIL hold[%0d] cyc %0d: got valid=%0b data=%0d, want valid=1 data=%0d",
                     g, cyc, valid_w[g], $signed(mon_cur.data), $signed(prev_beat[g].data));
          end
        end
        if (valid_w[g] && first_cyc[g] < 0) first_cyc[g] = cyc;
        if (valid_w[g] && ready) begin
          got_q[g].push_back(mon_cur);
          last_cyc[g] = cyc;
        end
        if (valid_w[g] && !ready) stall_m[g]++;
        prev_stall[g] = valid_w[g] && !ready;
        prev_beat[g]  = mon_cur;
        if (done_w[g]) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
      end
    end
  end

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk++;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = (rk % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic clear_cap();
    for (int g = 0; g < NDUT; g++) begin
      got_q[g].delete();
      first_cyc[g]  = -1;
      last_cyc[g]   = -1;
      done_cyc[g]   = -1;
      done_cnt[g]   = 0;
      stall_m[g]    = 0;
      prev_stall[g] = 1'b0;
    end
  endtask

  task automatic ram_wr(input int a, input int d);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    ram_m[a] = DW'(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic begin_seg(input int base, input int len, input int mode, output int acc);
    int leff;
    ready_mode = mode;
    clear_cap();
    cap_en = 1'b1;
    @(posedge clk);
    #1;
    seg_base = AW'(base);
    seg_len  = (AW + 1)'(len);
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b0;
    leff = (len > DEPTH) ? DEPTH : len;
    for (int g = 0; g < NDUT; g++)
      if (leff + fl_of(g) > 0) chk($sformatf("busy_after_start[%0d]", g), int'(busy_w[g]), 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit all;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      all = 1'b1;
      for (int g = 0; g < NDUT; g++) if (done_cnt[g] == 0) all = 1'b0;
    end while (!all && n < budget);
    chk("done_seen", int'(all), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(input int base, input int len, input int acc);
    int leff;
    int total;
    beat_t b;
    beat_t exp_q[$];
    leff = (len > DEPTH) ? DEPTH : len;
    for (int g = 0; g < NDUT; g++) begin
      exp_q.delete();
      total = leff + fl_of(g);
      for (int i = 0; i < total; i++) begin
        b.data  = (i < leff) ? ram_m[(base + i) % DEPTH] : '0;
        b.flush = (i >= leff);
        b.last  = (i == total - 1);
        exp_q.push_back(b);
      end
      chk($sformatf("beat_count[%0d]", g), got_q[g].size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q[g].size(); i++)
        chk_beat($sformatf("beat[%0d][%0d]", g, i), got_q[g][i], exp_q[i]);
      if (total > 0) begin
        chk($sformatf("first_valid_lat[%0d]", g), first_cyc[g] - acc, 2);
        chk($sformatf("done_after_last[%0d]", g), done_cyc[g] - last_cyc[g], 1);
      end else begin
        chk($sformatf("no_valid[%0d]", g), first_cyc[g], -1);
        chk($sformatf("done_lat_empty[%0d]", g), done_cyc[g] - acc, 0);
      end
      chk($sformatf("done_pulses[%0d]", g), done_cnt[g], 1);
      chk($sformatf("busy_idle[%0d]", g), int'(busy_w[g]), 0);
`ifdef FIR_STREAMER_STALL_CNT_EN
      chk($sformatf("stall_cnt[%0d]", g), int'(stall_w[g]), stall_m[g]);
`endif
    end
  endtask

  task automatic run_seg(input int base, input int len, input int mode);
    int acc;
    int leff;
    leff = (len > DEPTH) ? DEPTH : len;
    begin_seg(base, len, mode, acc);
    wait_done(4 * (leff + 130) + 50);
    cap_en = 1'b0;
    verify(base, len, acc);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("%s_valid[%0d]", tag, g), int'(valid_w[g]), 0);
      chk($sformatf("%s_data[%0d]", tag, g), int'(data_w[g]), 0);
      chk($sformatf("%s_flags[%0d]", tag, g), int'({last_w[g], flush_w[g], busy_w[g], done_w[g]}),
          0);
    end
  endtask

  initial begin
    seg_vec_t vecs [5];
    int acc;
    int n;
    int exp1 [6];
    vecs[0] = '{base: 0,     len: 4,     mode: 1, exp_beats_g0: 6};
    vecs[1] = '{base: 16382, len: 4,     mode: 0, exp_beats_g0: 6};
    vecs[2] = '{base: 0,     len: 0,     mode: 0, exp_beats_g0: 2};
    vecs[3] = '{base: 7,     len: 3,     mode: 2, exp_beats_g0: 5};
    vecs[4] = '{base: 100,   len: 20000, mode: 0, exp_beats_g0: 16386};
    exp1 = '{5, -3, 100, -65536, 0, 0};

    reset = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    seg_base = '0;
    seg_len = '0;
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b0;
    #2 reset = 1'b1;
    #10;
    chk_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = DW'($urandom);
      ram_m[i] = wr_data;
    end
    @(posedge clk);
    #1 wr_en = 1'b0;

    ram_wr(0, 5);
    ram_wr(1, -3);
    ram_wr(2, 100);
    ram_wr(3, -65536);
    ram_wr(16382, 1);
    ram_wr(16383, 2);

    run_seg(0, 4, 0);
    for (int i = 0; i < 6 && i < got_q[0].size(); i++) begin
      chk($sformatf("t1_data[%0d]", i), int'($signed(got_q[0][i].data)), exp1[i]);
      chk($sformatf("t1_flags[%0d]", i), int'({got_q[0][i].last, got_q[0][i].flush}),
          (i == 5) ? 3 : (i == 4) ? 1 : 0);
    end

    for (int v = 0; v < 5; v++) begin
      run_seg(vecs[v].base, vecs[v].len, vecs[v].mode);
      chk($sformatf("table_beats_g0[%0d]", v), got_q[0].size(), vecs[v].exp_beats_g0);
    end

    // Reset after the second beat of a 10-sample segment; RAM must survive.
    begin_seg(0, 10, 0, acc);
    n = 0;
    while (got_q[0].size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reset_mid_reached", got_q[0].size(), 2);
    #1 reset = 1'b1;
    cap_en = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    run_seg(0, 1, 0);

    // start and wr_en while busy must both be ignored.
    begin_seg(0, 10, 1, acc);
    repeat (3) @(posedge clk);
    #1;
    wr_en = 1'b1;
    wr_addr = AW'(2);
    wr_data = DW'(77);
    seg_base = AW'(500);
    seg_len = (AW + 1)'(5);
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b0;
    wait_done(400);
    cap_en = 1'b0;
    verify(0, 10, acc);
    run_seg(2, 1, 0);
    chk("ram2_kept", int'($signed(got_q[0][0].data)), 100);

    // start during DONE is dropped, start one cycle later is taken (instance 0 only).
    ready_mode = 0;
    clear_cap();
    cap_en = 1'b1;
    @(posedge clk);
    #1;
    seg_base = '0;
    seg_len = (AW + 1)'(1);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    n = 0;
    while (!done_w[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_cycle_seen", int'(done_w[0]), 1);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("start_in_done_ignored", int'(busy_w[0]), 0);
    @(posedge clk);
    #1;
    chk("start_after_done_taken", int'(busy_w[0]), 1);
    start_v[0] = 1'b0;
    n = 0;
    while (done_cnt[0] < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    cap_en = 1'b0;
    chk("done_cycle_beats", got_q[0].size(), 6);

    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 3)) ram_wr($urandom_range(0, DEPTH - 1), $urandom);
      if (k % 4 == 0) run_seg(DEPTH - 1 - $urandom_range(0, 20), $urandom_range(0, 40), k % 3);
      else run_seg($urandom_range(0, DEPTH - 1), $urandom_range(0, 40), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_sample_streamer.md
Name: fir_sample_streamer

Overview:
Sample source feeding the FIR filter's x_in. It holds a preloaded signed sample table, such as the 100 Hz / 2 kHz / 6 kHz / 11 kHz tone segments, and plays a requested segment out one sample per handshake. After each segment it appends FLUSH_LEN zero samples to drain the filter tap line, which replaces the bench practice of pulsing reset between tones.

Parameters:
DATA_W, 17, sample width (signed, matches filter x_in)
ADDR_W, 14, sample RAM address width
DEPTH, 16384, sample RAM entries (2**ADDR_W)
FLUSH_LEN, 123, zero samples appended after each segment (filter tap count); 0 allowed

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  sample RAM write strobe
wr_addr  in  ADDR_W  RAM write address
wr_data  in  DATA_W  RAM write data (signed)
start  in  1  one-cycle request to play a segment
seg_base  in  ADDR_W  first sample address, latched on accepted start
seg_len  in  ADDR_W+1  number of samples, latched on accepted start
out_valid  out  1  out_data holds a sample
out_ready  in  1  downstream accepts
out_data  out  DATA_W  signed sample to the filter
out_last  out  1  marks the final beat of the segment, including flush
flush_active  out  1  current beat is a flush zero
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: all outputs 0, FSM to IDLE, internal buffer emptied. RAM contents are not reset and survive reset.
- RAM: synchronous write and synchronous read with 1-cycle latency. Writes occur only in IDLE; wr_en while busy is ignored.
- FSM states: IDLE, PLAY, FLUSH, DONE.
- IDLE:
  - start=1 latches seg_base and seg_len and sets busy=1 next cycle.
  - If seg_len>0, go to PLAY.
  - If seg_len==0 and FLUSH_LEN>0, go to FLUSH.
  - If both are 0, go to DONE.
- start while busy is ignored.
- PLAY:
  - Reads addresses seg_base .. seg_base+seg_len-1, wrapping modulo DEPTH.
  - First out_valid is asserted 2 cycles after the accepted start.
  - With out_ready held high, throughput is one sample per cycle with no bubbles. This needs an internal 2-entry prefetch buffer so that no RAM read is lost under backpressure.
- Handshake: a beat transfers on out_valid & out_ready. While out_valid=1 and out_ready=0, out_data, out_last and flush_active hold stable. out_valid never drops without a transfer.
- FLUSH:
  - Entered when the last PLAY sample has been issued.
  - Emits FLUSH_LEN beats with out_data=0 and flush_active=1, contiguous with PLAY (no bubble) if out_ready=1.
- out_last:
  - On the final flush beat.
  - If FLUSH_LEN==0, on the final PLAY beat instead.
- DONE: done=1 for exactly one cycle, the cycle after the last beat transfers. busy drops in the same cycle. Return to IDLE.
- A start that arrives in the DONE cycle is ignored. A start that arrives in the next cycle is accepted.
- Reset mid-segment: outputs go to 0 immediately (async). No partial segment resumes after reset.
- seg_len greater than DEPTH: clamp to DEPTH.

Optional Feature:
Macro FIR_STREAMER_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [31:0].
  - Counts cycles with out_valid=1 and out_ready=0, saturating at 2**32-1.
  - Clears on reset and on each accepted start.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package fir_stream_pkg:
  - state enum (IDLE/PLAY/FLUSH/DONE)
  - default widths (SAMPLE_W=17, TAP_CNT=123) shared with the filter
- Sub-module fir_sample_ram: single-port-write / single-port-read synchronous RAM, DATA_W x DEPTH, no reset.

Test Plan:
1. Write RAM[0..3] = 5, -3, 100, -65536; start with base=0, len=4, out_ready=1, FLUSH_LEN=2.
   - Out beats: 5, -3, 100, -65536, 0, 0.
   - out_last on the 6th beat; flush_active on beats 5–6.
   - done 1 cycle after beat 6; first valid 2 cycles after start.
2. Same segment with out_ready toggling 1,0,0,1,...
   - Identical beat sequence, no loss or duplication.
   - Data stable during stalls.
   - With FIR_STREAMER_STALL_CNT_EN, stall_cnt equals the number of stalled valid cycles.
3. base=16382, len=4 with RAM[16382]=1, [16383]=2, [0]=3, [1]=4.
   - Output 1, 2, 3, 4: verifies wrap-around.
4. len=0, FLUSH_LEN=123: exactly 123 zero beats, out_last on beat 123, then done.
5. Assert reset after the 2nd beat of a 10-sample segment.
   - All outputs 0 at once, busy=0.
   - New start base=0, len=1 returns RAM[0]: RAM retained.
6. start and wr_en (addr 2, data 77) asserted while busy.
   - Both ignored: the segment plays the original RAM[2].
   - A read of addr 2 after done shows the old value.
